// File: rtl/vx_raster_tile_sched_pkg.sv
// Shared types, widths and defaults for the raster tile scheduler.
package VX_raster_pkg;

  localparam int RASTER_ADDR_BITS       = 32;
  localparam int RASTER_TILE_BITS       = 16;
  localparam int RASTER_TILE_DESC_BYTES = 8;
  localparam int RASTER_MAX_PENDING     = 4;

  function automatic int tag_bits(input int max_pending);
    return (max_pending > 1) ? $clog2(max_pending) : 1;
  endfunction

  localparam int RASTER_TAG_BITS = tag_bits(RASTER_MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } raster_sched_state_e;

  typedef struct packed {
    logic [RASTER_ADDR_BITS-1:0] tbuf_addr;
    logic [RASTER_TILE_BITS-1:0] tile_count;
  } raster_dcrs_t;

endpackage

// File: rtl/vx_raster_tile_sched_rr_dispatch.sv
// Single-entry output register feeding the raster slices in strict round-robin order.
module VX_raster_rr_dispatch #(
  parameter int NUM_SLICES = 2,
  parameter int DATA_BITS  = 64,
  localparam int RR_BITS   = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_BITS-1:0]  load_data,
  output logic                  empty,
  output logic                  drain,
  output logic [NUM_SLICES-1:0] tile_valid,
  output logic [DATA_BITS-1:0]  tile_data,
  input  logic [NUM_SLICES-1:0] tile_ready
);

  logic               full;
  logic [RR_BITS-1:0] rr;

  assign empty = !full;
  // Only the slice whose turn it is can drain the register; others are never offered data.
  assign drain = full && tile_ready[rr];

  always_comb begin
    tile_valid     = '0;
    tile_valid[rr] = full;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      full <= 1'b0;
      rr   <= '0;
    end else begin
      if (load) begin
        full <= 1'b1;
      end else if (drain) begin
        full <= 1'b0;
      end
      if (drain) begin
        rr <= (rr == RR_BITS'(NUM_SLICES - 1)) ? '0 : rr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      tile_data <= load_data;
    end
  end

endmodule

// File: rtl/vx_raster_tile_sched.sv
// Tile scheduler: fetches tile descriptors from the tile buffer and hands them to raster slices.
module vx_raster_tile_sched
  import VX_raster_pkg::*;
#(
  parameter int NUM_SLICES      = 2,
  parameter int MAX_PENDING     = 4,
  parameter int TILE_DESC_BYTES = RASTER_TILE_DESC_BYTES,
  parameter int TILE_DATA_BITS  = 64,
  localparam int TAG_BITS       = tag_bits(MAX_PENDING)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  raster_dcrs_t                raster_dcrs,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [RASTER_ADDR_BITS-1:0] mem_req_addr,
  output logic [TAG_BITS-1:0]         mem_req_tag,
  input  logic                        mem_rsp_valid,
  output logic                        mem_rsp_ready,
  input  logic [TILE_DATA_BITS-1:0]   mem_rsp_data,
  input  logic [TAG_BITS-1:0]         mem_rsp_tag,
  output logic [NUM_SLICES-1:0]       tile_valid,
  output logic [TILE_DATA_BITS-1:0]   tile_data,
  input  logic [NUM_SLICES-1:0]       tile_ready,
  output raster_sched_state_e         dbg_state
);

  localparam int PEND_BITS = $clog2(MAX_PENDING) + 1;

  raster_sched_state_e         state, state_next;
  logic [RASTER_ADDR_BITS-1:0] base;
  logic [RASTER_TILE_BITS-1:0] total, req_idx, rsp_cnt;
  logic [PEND_BITS-1:0]        pending;
  logic launch, fetching, req_fire, rsp_fire, load_fire, out_empty, out_drain;

  assign launch    = (state == IDLE) && start;
  assign fetching  = (state == FETCH);
  assign req_fire  = mem_req_valid && mem_req_ready;
  assign rsp_fire  = mem_rsp_valid && mem_rsp_ready;
  assign load_fire = fetching && rsp_fire;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero-tile run spends one cycle in FETCH, so done follows start by two cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if ((rsp_cnt == total) && (out_empty || out_drain)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE);
    mem_req_valid = fetching && (req_idx < total) && (pending < PEND_BITS'(MAX_PENDING));
    mem_rsp_ready = fetching ? (out_empty || out_drain) : 1'b1;
  end

  // Outside FETCH responses are accepted and discarded, which flushes stale reads after a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      base    <= '0;
      total   <= '0;
      req_idx <= '0;
      rsp_cnt <= '0;
      pending <= '0;
    end else if (launch) begin
      base    <= raster_dcrs.tbuf_addr;
      total   <= raster_dcrs.tile_count;
      req_idx <= '0;
      rsp_cnt <= '0;
      pending <= '0;
    end else begin
      if (req_fire) req_idx <= req_idx + 1'b1;
      if (load_fire) rsp_cnt <= rsp_cnt + 1'b1;
      if (req_fire && !load_fire) begin
        pending <= pending + 1'b1;
      end else if (!req_fire && load_fire) begin
        pending <= pending - 1'b1;
      end
    end
  end

  assign mem_req_addr = base + RASTER_ADDR_BITS'(req_idx) * RASTER_ADDR_BITS'(TILE_DESC_BYTES);
  assign mem_req_tag  = req_idx[TAG_BITS-1:0];

  property p_rsp_in_order;
    @(posedge clk) disable iff (reset) load_fire |-> (mem_rsp_tag == rsp_cnt[TAG_BITS-1:0]);
  endproperty
  a_rsp_in_order: assert property (p_rsp_in_order);

  VX_raster_rr_dispatch #(
    .NUM_SLICES (NUM_SLICES),
    .DATA_BITS  (TILE_DATA_BITS)
  ) dispatch (
    .clk        (clk),
    .reset      (reset),
    .clear      (launch),
    .load       (load_fire),
    .load_data  (mem_rsp_data),
    .empty      (out_empty),
    .drain      (out_drain),
    .tile_valid (tile_valid),
    .tile_data  (tile_data),
    .tile_ready (tile_ready)
  );

endmodule

// File: tb/tb_vx_raster_tile_sched.sv
// Bench for the raster tile scheduler: memory and slice models, scoreboard, directed and random runs.
module tb_vx_raster_tile_sched;
  import VX_raster_pkg::*;

  localparam int NS = 2;
  localparam int MP = 4;
  localparam int DB = 64;
  localparam int TB = $clog2(MP);

  logic                        clk = 1'b0;
  logic                        reset;
  raster_dcrs_t                raster_dcrs;
  logic                        start, busy, done;
  logic                        mem_req_valid, mem_req_ready;
  logic [RASTER_ADDR_BITS-1:0] mem_req_addr;
  logic [TB-1:0]               mem_req_tag, mem_rsp_tag;
  logic                        mem_rsp_valid, mem_rsp_ready;
  logic [DB-1:0]               mem_rsp_data, tile_data;
  logic [NS-1:0]               tile_valid, tile_ready;
  raster_sched_state_e         dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vx_raster_tile_sched #(
    .NUM_SLICES      (NS),
    .MAX_PENDING     (MP),
    .TILE_DESC_BYTES (8),
    .TILE_DATA_BITS  (DB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raster_dcrs   (raster_dcrs),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_tag   (mem_rsp_tag),
    .tile_valid    (tile_valid),
    .tile_data     (tile_data),
    .tile_ready    (tile_ready),
    .dbg_state     (dbg_state)
  );

  // Handshakes: a transfer happens on a rising edge when valid and ready are both high.
  logic [RASTER_ADDR_BITS+TB-1:0] exp_req_q[$];
  logic [8+DB-1:0]                exp_tile_q[$];
  logic [DB+TB-1:0]               mem_q[$];

  bit          mem_rsp_en = 1'b1;
  bit          mem_rand = 1'b0;
  bit          slice_rand = 1'b0;
  bit [NS-1:0] slice_hold = '0;
  bit          shown = 1'b0;
  bit          run_active = 1'b0;
  bit          nonzero_run = 1'b0;
  int          outstanding = 0;
  int          req_seen = 0;
  int          tile_seen = 0;
  int          done_seen = 0;
  int          last_tile_cyc = 0;

  function automatic logic [DB-1:0] desc_of(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // memory model: in-order reads, random request/response throttling
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) mem_q.push_back({desc_of(mem_req_addr), mem_req_tag});
      if (mem_rsp_valid && mem_rsp_ready) begin
        mem_q.delete(0);
        shown = 1'b0;
      end
      @(posedge clk);
      #1;
      mem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!shown && mem_q.size() > 0 && mem_rsp_en && (!mem_rand || $urandom_range(0, 2) != 0))
        shown = 1'b1;
      mem_rsp_valid = shown;
      if (shown) {mem_rsp_data, mem_rsp_tag} = mem_q[0];
    end
  end

  // slice model
  initial begin
    tile_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
        tile_ready[i] = slice_hold[i] ? 1'b0 : (slice_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // monitor / scoreboard
  initial begin
    logic [RASTER_ADDR_BITS+TB-1:0] er;
    logic [8+DB-1:0]                et;
    int s;
    bit rsp_prev;
    rsp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rsp_prev = 1'b0;
        continue;
      end
      check("tile_valid_onehot0", 128'($onehot0(tile_valid)), 128'd1);
      if (rsp_prev) check("rsp_to_tile_valid", 128'(|tile_valid), 128'd1);
      rsp_prev = run_active && mem_rsp_valid && mem_rsp_ready;
      if (mem_req_valid && mem_req_ready) begin
        req_seen++;
        check("pending_cap", 128'(outstanding < MP), 128'd1);
        check("req_expected_left", 128'(exp_req_q.size() > 0), 128'd1);
        if (exp_req_q.size() > 0) begin
          er = exp_req_q.pop_front();
          check("req_addr", 128'(mem_req_addr), 128'(er[TB+31:TB]));
          check("req_tag", 128'(mem_req_tag), 128'(er[TB-1:0]));
        end
        outstanding++;
      end
      if (run_active && mem_rsp_valid && mem_rsp_ready) outstanding--;
      if (|(tile_valid & tile_ready)) begin
        s = 0;
        for (int i = 0; i < NS; i++) if (tile_valid[i]) s = i;
        tile_seen++;
        last_tile_cyc = cyc;
        check("tile_expected_left", 128'(exp_tile_q.size() > 0), 128'd1);
        if (exp_tile_q.size() > 0) begin
          et = exp_tile_q.pop_front();
          check("tile_slice", 128'(s), 128'(et[8+DB-1:DB]));
          check("tile_data", 128'(tile_data), 128'(et[DB-1:0]));
        end
      end
      if (done) begin
        done_seen++;
        check("done_reqs_left", 128'(exp_req_q.size()), 128'd0);
        check("done_tiles_left", 128'(exp_tile_q.size()), 128'd0);
        if (nonzero_run) check("done_latency", 128'(cyc - last_tile_cyc), 128'd1);
      end
    end
  end

  // driver tasks
  task automatic start_run(input logic [31:0] base, input int count);
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      a = base + 32'(i) * 32'd8;
      exp_req_q.push_back({a, TB'(i)});
      exp_tile_q.push_back({8'(i % NS), desc_of(a)});
    end
    nonzero_run = (count != 0);
    @(posedge clk);
    #1;
    raster_dcrs.tbuf_addr  = base;
    raster_dcrs.tile_count = count[15:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    run_active = 1'b1;
    @(negedge clk);
    check("busy_rise", 128'(busy), 128'd1);
    check("done_low_after_start", 128'(done), 128'd0);
    check("req_valid_rise", 128'(mem_req_valid), 128'(count != 0));
  endtask

  // lat counts cycles after the first post-start cycle until done is seen
  task automatic wait_done(input int budget, output int lat);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen_in_budget", 128'(done), 128'd1);
    lat = n;
    @(negedge clk);
    run_active = 1'b0;
    check("done_one_cycle", 128'(done), 128'd0);
    check("busy_fall", 128'(busy), 128'd0);
  endtask

  initial begin
    int lat, r0, t0, d0, n, cnt;
    logic [31:0] b;
    reset = 1'b1;
    start = 1'b0;
    raster_dcrs = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_req_valid", 128'(mem_req_valid), 128'd0);
    check("rst_tile_valid", 128'(tile_valid), 128'd0);
    check("rst_rsp_ready", 128'(mem_rsp_ready), 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // basic run, everything always ready
    r0 = req_seen; t0 = tile_seen; d0 = done_seen;
    start_run(32'h1000, 5);
    wait_done(200, lat);
    check("basic_latency", 128'(lat), 128'd7);
    check("basic_reqs", 128'(req_seen - r0), 128'd5);
    check("basic_tiles", 128'(tile_seen - t0), 128'd5);
    check("basic_done_count", 128'(done_seen - d0), 128'd1);

    // pending cap with responses withheld
    mem_rsp_en = 1'b0;
    r0 = req_seen;
    start_run(32'h2000, 6);
    repeat (10) @(negedge clk);
    check("cap_reqs", 128'(req_seen - r0), 128'd4);
    check("cap_req_valid_low", 128'(mem_req_valid), 128'd0);
    mem_rsp_en = 1'b1;
    wait_done(200, lat);
    check("cap_reqs_total", 128'(req_seen - r0), 128'd6);

    // slice 1 stalled
    slice_hold[1] = 1'b1;
    t0 = tile_seen;
    start_run(32'h0000_4400, 6);
    repeat (10) @(negedge clk);
    check("stall_tile_valid", 128'(tile_valid), 128'(2'b10));
    check("stall_rsp_ready", 128'(mem_rsp_ready), 128'd0);
    check("stall_tiles", 128'(tile_seen - t0), 128'd1);
    slice_hold[1] = 1'b0;
    wait_done(200, lat);
    check("stall_tiles_total", 128'(tile_seen - t0), 128'd6);

    // zero tiles
    r0 = req_seen; d0 = done_seen;
    start_run(32'h3000, 0);
    wait_done(20, lat);
    check("zero_latency", 128'(lat), 128'd1);
    check("zero_reqs", 128'(req_seen - r0), 128'd0);
    check("zero_done_count", 128'(done_seen - d0), 128'd1);

    // start while busy and DCR change mid-run
    mem_rand = 1'b1; slice_rand = 1'b1;
    r0 = req_seen; t0 = tile_seen; d0 = done_seen;
    start_run(32'h5000, 7);
    @(posedge clk);
    #1;
    raster_dcrs.tbuf_addr  = 32'h9000;
    raster_dcrs.tile_count = 16'd20;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(400, lat);
    repeat (5) @(negedge clk);
    check("busy_start_reqs", 128'(req_seen - r0), 128'd7);
    check("busy_start_tiles", 128'(tile_seen - t0), 128'd7);
    check("busy_start_done_count", 128'(done_seen - d0), 128'd1);
    check("busy_start_idle", 128'(busy), 128'd0);

    // address wrap
    mem_rand = 1'b0; slice_rand = 1'b0;
    r0 = req_seen;
    start_run(32'hFFFF_FFF0, 4);
    wait_done(200, lat);
    check("wrap_reqs", 128'(req_seen - r0), 128'd4);

    // reset after two of six tiles
    mem_rand = 1'b1;
    t0 = tile_seen;
    start_run(32'h0000_7000, 6);
    n = 0;
    while ((tile_seen - t0) < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_two_tiles", 128'(tile_seen - t0 >= 2), 128'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_active = 1'b0;
    outstanding = 0;
    exp_req_q.delete();
    exp_tile_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_req_valid", 128'(mem_req_valid), 128'd0);
    check("midrst_tile_valid", 128'(tile_valid), 128'd0);
    check("midrst_rsp_ready", 128'(mem_rsp_ready), 128'd1);
    n = 0;
    while (mem_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrst_stale_drained", 128'(mem_q.size()), 128'd0);
    check("midrst_idle_tile_valid", 128'(tile_valid), 128'd0);
    r0 = req_seen; t0 = tile_seen;
    start_run(32'h0000_8000, 3);
    wait_done(300, lat);
    check("midrst_rerun_reqs", 128'(req_seen - r0), 128'd3);
    check("midrst_rerun_tiles", 128'(tile_seen - t0), 128'd3);

    // random runs
    for (int k = 0; k < 8; k++) begin
      mem_rand   = 1'($urandom_range(0, 1));
      slice_rand = 1'($urandom_range(0, 1));
      b   = $urandom;
      cnt = $urandom_range(1, 12);
      r0 = req_seen; t0 = tile_seen; d0 = done_seen;
      start_run(b, cnt);
      wait_done(800, lat);
      check("rand_reqs", 128'(req_seen - r0), 128'(cnt));
      check("rand_tiles", 128'(tile_seen - t0), 128'(cnt));
      check("rand_done_count", 128'(done_seen - d0), 128'd1);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
